rtg_fetch_responder: RTL

RTG_FETCH_RESPONDER -- requirements
Module: rtg_fetch_responder

---
 rtl/rtg_fetch_responder.sv | 108 ++++++++++
 1 files changed

// File: rtl/rtg_fetch_responder.sv
// Line-fetch responder: turns a stream fetch request into one SDRAM video-slot
// request, then forwards a BURST_WORDS-word read burst with a watchdog on inter-word gaps.
module rtg_fetch_responder #(
    parameter int BURST_WORDS = 8,
    parameter int TIMEOUT     = 255
) (
    input  logic        clk_114,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [25:0] fetch_addr,
    input  logic        fetch_pri,
    output logic        fetch_ack,
    output logic [15:0] fetch_d,
    output logic        fetch_fill,
    output logic        sdr_req,
    output logic [25:0] sdr_addr,
    output logic        sdr_pri,
    input  logic        sdr_grant,
    input  logic [15:0] sdr_d,
    input  logic        sdr_valid,
    output logic        busy,
    output logic        err_timeout
);

    localparam int WW = $clog2(BURST_WORDS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] LAST_W = WW'(BURST_WORDS);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

    state_t        state, state_n;
    logic [WW-1:0] wcnt, wcnt_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [25:0]   addr_n;
    logic [15:0]   d_n;
    logic          ack_n, fill_n, err_n;

    always_ff @(posedge clk_114) begin
        if (reset) begin
            state       <= IDLE;
            wcnt        <= '0;
            tcnt        <= '0;
            sdr_addr    <= '0;
            fetch_d     <= '0;
            fetch_ack   <= 1'b0;
            fetch_fill  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            wcnt        <= wcnt_n;
            tcnt        <= tcnt_n;
            sdr_addr    <= addr_n;
            fetch_d     <= d_n;
            fetch_ack   <= ack_n;
            fetch_fill  <= fill_n;
            err_timeout <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        tcnt_n  = tcnt;
        addr_n  = sdr_addr;
        d_n     = fetch_d;
        ack_n   = 1'b0;
        fill_n  = 1'b0;
        err_n   = err_timeout;
        case (state)
            IDLE: begin
                if (fetch_req) begin
                    addr_n  = fetch_addr & ~26'hF;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (sdr_grant) begin
                    ack_n   = 1'b1;
                    wcnt_n  = '0;
                    tcnt_n  = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                // a stalled burst is dropped even if a word shows up on the abort edge
                if (tcnt == T_MAX) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else if (sdr_valid) begin
                    d_n    = sdr_d;
                    fill_n = 1'b1;
                    wcnt_n = wcnt + 1'b1;
                    tcnt_n = '0;
                    if (wcnt_n == LAST_W) state_n = IDLE;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign sdr_req = (state == REQ);
    assign sdr_pri = (state == REQ) && fetch_pri;
    assign busy    = (state != IDLE);

endmodule
